// File: rtl/zkbdmus_pkg.sv
// zkbdmus_pkg: command codes, FSM states and mouse targets for the AVR keyboard/mouse SPI loader
package zkbdmus_pkg;
  localparam logic [7:0] CMD_KBD    = 8'h10;
  localparam logic [7:0] CMD_MUSX   = 8'h20;
  localparam logic [7:0] CMD_MUSY   = 8'h21;
  localparam logic [7:0] CMD_MUSBTN = 8'h22;
  localparam int KBD_BYTES_DEF = 5;
  typedef enum logic [2:0] {IDLE, CMD, KBD, MUS, IGNORE} state_e;
  typedef enum logic [1:0] {MUS_X, MUS_Y, MUS_BTN} tgt_e;
endpackage

// File: rtl/zkbdmus_spi_loader_sync.sv
// spi_sync_edge: multi-flop synchroniser with one extra flop for rise/fall detection
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= {(STAGES+1){RST_VAL}};
    else sh_q <= {sh_q[STAGES-1:0], d_i};
  assign lvl_o  = sh_q[STAGES-1];
  assign rise_o = sh_q[STAGES-1] & ~sh_q[STAGES];
  assign fall_o = ~sh_q[STAGES-1] & sh_q[STAGES];
endmodule

// File: rtl/zkbdmus_spi_loader.sv
// zkbdmus_spi_loader: SPI slave that commits complete keyboard/mouse frames from the AVR
module zkbdmus_spi_loader
  import zkbdmus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int KBD_BYTES   = KBD_BYTES_DEF
) (
  input  logic                   fclk,
  input  logic                   rst_n,
  input  logic                   spics_n,
  input  logic                   spick,
  input  logic                   spido,
  output logic [8*KBD_BYTES-1:0] kbd_out,
  output logic                   kbd_stb,
  output logic [7:0]             mus_out,
  output logic                   mus_xstb,
  output logic                   mus_ystb,
  output logic                   mus_btnstb
);
  localparam int KW = 8 * KBD_BYTES;
  localparam int NW = $clog2(KBD_BYTES + 1);
  logic cs_lvl, cs_rise, cs_fall, sck_rise, do_lvl, samp;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, mus_q, mus_d;
  logic done_q, done_d, kgo_q, kgo_d, mgo_q, mgo_d;
  logic [NW-1:0] n_q, n_d;
  logic [KW-1:0] ksh_q, ksh_d, kbd_q, kbd_d;
  logic [3:0] stb_q, stb_d;
  state_e st_q, st_d;
  tgt_e tgt_q, tgt_d;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(fclk), .rst_n(rst_n), .d_i(spics_n), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(fclk), .rst_n(rst_n), .d_i(spick), .lvl_o(), .rise_o(sck_rise), .fall_o());
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_do (
    .clk(fclk), .rst_n(rst_n), .d_i(spido), .lvl_o(do_lvl), .rise_o(), .fall_o());
  // Commits are taken from flags set one cycle earlier, so a cs_rise cannot cancel them.
  always_comb begin
    samp   = sck_rise & ~cs_lvl;
    cnt_d  = cs_fall ? 3'd0 : cnt_q;
    if (samp) cnt_d = cnt_d + 3'd1;
    sh_d   = samp ? {sh_q[6:0], do_lvl} : sh_q;
    done_d = samp & (cnt_d == 3'd0);
    st_d   = st_q;
    tgt_d  = tgt_q;
    n_d    = n_q;
    ksh_d  = ksh_q;
    kgo_d  = 1'b0;
    mgo_d  = 1'b0;
    kbd_d  = kgo_q ? ksh_q : kbd_q;
    mus_d  = mgo_q ? sh_q : mus_q;
    stb_d  = {kgo_q, mgo_q & (tgt_q == MUS_X), mgo_q & (tgt_q == MUS_Y), mgo_q & (tgt_q == MUS_BTN)};
    if (cs_rise) st_d = IDLE;
    else begin
      unique case (st_q)
        IDLE: if (cs_fall) begin
          st_d = CMD;
          n_d  = '0;
        end
        CMD: if (done_q) begin
          st_d  = (sh_q == CMD_KBD) ? KBD :
                  (sh_q inside {CMD_MUSX, CMD_MUSY, CMD_MUSBTN}) ? MUS : IGNORE;
          tgt_d = tgt_e'(sh_q[1:0]);
        end
        KBD: if (done_q) begin
          ksh_d = {ksh_q[KW-9:0], sh_q};
          n_d   = n_q + NW'(1);
          if (n_q == NW'(KBD_BYTES - 1)) begin
            kgo_d = 1'b1;
            st_d  = IGNORE;
          end
        end
        MUS: if (done_q) begin
          mgo_d = 1'b1;
          st_d  = IGNORE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
      st_q   <= IDLE;
      tgt_q  <= MUS_X;
      n_q    <= '0;
      ksh_q  <= '0;
      kgo_q  <= 1'b0;
      mgo_q  <= 1'b0;
      kbd_q  <= '0;
      mus_q  <= '0;
      stb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      done_q <= done_d;
      st_q   <= st_d;
      tgt_q  <= tgt_d;
      n_q    <= n_d;
      ksh_q  <= ksh_d;
      kgo_q  <= kgo_d;
      mgo_q  <= mgo_d;
      kbd_q  <= kbd_d;
      mus_q  <= mus_d;
      stb_q  <= stb_d;
    end
  assign kbd_out    = kbd_q;
  assign mus_out    = mus_q;
  assign kbd_stb    = stb_q[3];
  assign mus_xstb   = stb_q[2];
  assign mus_ystb   = stb_q[1];
  assign mus_btnstb = stb_q[0];
endmodule

// File: tb/tb_zkbdmus_spi_loader.sv
// tb_zkbdmus_spi_loader: scoreboard bench driving SPI frames against a frame-level model
module tb_zkbdmus_spi_loader;
  typedef struct {
    logic [3:0]  k;
    logic [39:0] d;
  } exp_t;
  logic fclk, rst_n, spics_n, spick, spido;
  logic [39:0] kbd_out;
  logic [7:0] mus_out;
  logic kbd_stb, mus_xstb, mus_ystb, mus_btnstb;
  int total = 0, bad = 0;
  exp_t q[$];
  logic [7:0] fb[$];
  logic [39:0] mkbd = '0;
  logic [7:0] mmus = '0;
  logic [3:0] stb;
  logic prev = 1'b0;
  exp_t e;
  zkbdmus_spi_loader dut (
    .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
    .kbd_out(kbd_out), .kbd_stb(kbd_stb), .mus_out(mus_out),
    .mus_xstb(mus_xstb), .mus_ystb(mus_ystb), .mus_btnstb(mus_btnstb));
  initial fclk = 1'b0;
  always #5 fclk = ~fclk;
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Frame-level reference: what a complete frame of nb received bytes must commit.
  function automatic void model(input int nb);
    logic [39:0] d = '0;
    if (nb >= 6 && fb[0] == 8'h10) begin
      for (int i = 1; i <= 5; i++) d = {d[31:0], fb[i]};
      q.push_back('{k: 4'b1000, d: d});
      mkbd = d;
    end else if (nb >= 2 && fb[0] inside {8'h20, 8'h21, 8'h22}) begin
      q.push_back('{k: 4'b0100 >> (fb[0] - 8'h20), d: {32'h0, fb[1]}});
      mmus = fb[1];
    end
  endfunction
  always @(negedge fclk) begin
    stb = {kbd_stb, mus_xstb, mus_ystb, mus_btnstb};
    if (stb != 4'b0) begin
      chk("stb_onehot", 40'($countones(stb)), 40'd1);
      chk("stb_width", {39'h0, prev}, 40'h0);
      if (q.size() == 0) chk("unexpected_stb", {36'h0, stb}, 40'h0);
      else begin
        e = q.pop_front();
        chk("stb_kind", {36'h0, stb}, {36'h0, e.k});
        chk("stb_data", stb[3] ? kbd_out : {32'h0, mus_out}, e.d);
      end
    end
    prev = (stb != 4'b0);
  end
  task automatic send(input int stop, input bit rst_abort);
    int nbits = (stop < 0) ? fb.size() * 8 : stop;
    int h = $urandom_range(3, 6);
    if (!rst_abort) model(stop < 0 ? fb.size() : stop / 8);
    spics_n = 1'b0;
    repeat (5) @(negedge fclk);
    for (int i = 0; i < nbits; i++) begin
      spido = fb[i / 8][7 - (i % 8)];
      repeat (h) @(negedge fclk);
      spick = 1'b1;
      repeat (h) @(negedge fclk);
      spick = 1'b0;
    end
    if (rst_abort) begin
      rst_n = 1'b0;
      #1;
      chk("rst_mid_kbd", kbd_out, 40'h0);
      chk("rst_mid_mus", {32'h0, mus_out}, 40'h0);
      mkbd = '0;
      mmus = '0;
      q.delete();
      repeat (4) @(negedge fclk);
      rst_n = 1'b1;
    end
    repeat (h) @(negedge fclk);
    spics_n = 1'b1;
    spido = 1'b0;
    repeat (15) @(negedge fclk);
    chk("pending_stb", 40'(q.size()), 40'h0);
    chk("kbd_hold", kbd_out, mkbd);
    chk("mus_hold", {32'h0, mus_out}, {32'h0, mmus});
  endtask
  initial begin
    rst_n = 1'b0;
    spics_n = 1'b1;
    spick = 1'b0;
    spido = 1'b0;
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;
    repeat (100) @(negedge fclk);
    chk("reset_kbd", kbd_out, 40'h0);
    chk("reset_mus", {32'h0, mus_out}, 40'h0);
    fb = {8'h10, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01}; send(-1, 1'b0);
    chk("kbd_value", kbd_out, 40'h80_0000_0001);
    fb = {8'h20, 8'h05}; send(-1, 1'b0);
    fb = {8'h21, 8'hFB}; send(-1, 1'b0);
    fb = {8'h22, 8'hFA}; send(-1, 1'b0);
    chk("mus_btn_value", {32'h0, mus_out}, 40'hFA);
    fb = {8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD}; send(35, 1'b0);
    fb = {8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}; send(-1, 1'b0);
    fb = {8'h7E, 8'h11, 8'h22}; send(-1, 1'b0);
    fb = {8'h20, 8'h33, 8'h44}; send(-1, 1'b0);
    chk("mus_extra_ignored", {32'h0, mus_out}, 40'h33);
    fb = {8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55}; send(20, 1'b1);
    fb = {8'h22, 8'h07}; send(-1, 1'b0);
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 7);
      int sel = $urandom_range(0, 4);
      fb = {};
      fb.push_back(sel == 0 ? 8'h10 : sel == 1 ? 8'h20 : sel == 2 ? 8'h21 : sel == 3 ? 8'h22 : 8'($urandom));
      for (int i = 1; i < len; i++) fb.push_back(8'($urandom));
      send(($urandom_range(0, 3) == 0) ? $urandom_range(1, len * 8 - 1) : -1, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
